// File: rtl/sd_acq_pkg.sv
// Shared types and constants for the spin-echo acquisition-window sequencer.
package sd_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_OPEN = 3'd1,
    ST_ACQ       = 3'd2,
    ST_TAIL_WAIT = 3'd3,
    ST_TAIL_ACQ  = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERR       = 3'd6
  } acq_state_e;

  localparam logic [1:0] MODE_SINGLE     = 2'd0;
  localparam logic [1:0] MODE_TRAIN      = 2'd1;
  localparam logic [1:0] MODE_TRAIN_TAIL = 2'd2;

  // Reserved mode encoding 3 behaves as a single window.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    logic [1:0] r;
    case (m)
      MODE_TRAIN:      r = MODE_TRAIN;
      MODE_TRAIN_TAIL: r = MODE_TRAIN_TAIL;
      default:         r = MODE_SINGLE;
    endcase
    return r;
  endfunction

  // States in which a sequence is in progress (watchdog, abort and start-drop apply).
  function automatic logic is_active(input acq_state_e s);
    logic r;
    case (s)
      ST_WAIT_OPEN, ST_ACQ, ST_TAIL_WAIT, ST_TAIL_ACQ: r = 1'b1;
      default:                                         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sd_acq_wdog.sv
// Watchdog: counts cycles spent in the current sequencer state and flags
// expiry once that count reaches a non-zero limit.
module sd_acq_wdog #(
  parameter int TOW = 20
) (
  input  logic           dds,
  input  logic           rst,
  input  logic           clr,
  input  logic [TOW-1:0] limit,
  output logic           expired
);

  logic [TOW-1:0] cnt_q;
  logic [TOW-1:0] cnt_d;
  logic [TOW:0]   elapsed_s;

  // Next count: restart on clear, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {TOW{1'b0}};
    end else if (cnt_q != {TOW{1'b1}}) begin
      cnt_d = cnt_q + TOW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge dds or posedge rst) begin
    if (rst) begin
      cnt_q <= {TOW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds completed cycles; the current cycle makes it cnt_q+1 at the
  // closing edge, so the limit is reached after exactly `limit` cycles.
  assign elapsed_s = {1'b0, cnt_q} + (TOW+1)'(1);
  assign expired   = (limit != {TOW{1'b0}}) && (elapsed_s == {1'b0, limit});

endmodule

// File: rtl/sd_acq_seq.sv
// Acquisition-window sequencer: arms on start, opens/closes receive-enable
// windows on timer events for single, echo-train and train+tail modes.
module sd_acq_seq
  import sd_acq_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int CNTW = 16,
  parameter int TOW  = 20
) (
  input  logic            dds,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [NCH-1:0]  ch_mask,
  input  logic [NCH-1:0]  tail_mask,
  input  logic [CNTW-1:0] echo_num,
  input  logic [TOW-1:0]  timeout,
  input  logic            win_open,
  input  logic            win_close,
  input  logic            abort,
  output logic [NCH-1:0]  en,
  output logic [CNTW-1:0] echo_idx,
  output logic            busy,
  output logic            stateover,
  output logic            done,
  output logic            err
);

  acq_state_e      state_q, state_d;
  logic [CNTW-1:0] idx_q, idx_d;
  logic [1:0]      mode_q, mode_d;
  logic [NCH-1:0]  ch_mask_q, ch_mask_d;
  logic [NCH-1:0]  tail_mask_q, tail_mask_d;
  logic [CNTW-1:0] echo_num_q, echo_num_d;
  logic [TOW-1:0]  timeout_q, timeout_d;

  logic [NCH-1:0]  en_q, en_d;
  logic            busy_q, busy_d;
  logic            stateover_q, stateover_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [CNTW-1:0] idx_inc_s;
  logic            last_win_s;
  logic [1:0]      mode_in_s;
  logic            wdog_clr_s;
  logic            wdog_expired_s;

  assign mode_in_s  = norm_mode(mode);
  assign idx_inc_s  = (idx_q == {CNTW{1'b1}}) ? idx_q : idx_q + CNTW'(1);
  assign last_win_s = (({1'b0, idx_q} + (CNTW+1)'(1)) == {1'b0, echo_num_q});

  // The watchdog restarts on every state change and stays cleared outside a sequence.
  assign wdog_clr_s = (state_d != state_q) || !is_active(state_q);

  sd_acq_wdog #(.TOW(TOW)) u_wdog (
    .dds     (dds),
    .rst     (rst),
    .clr     (wdog_clr_s),
    .limit   (timeout_q),
    .expired (wdog_expired_s)
  );

  // Next state, echo counter and config latches; abort > start drop > watchdog > window events.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    ch_mask_d   = ch_mask_q;
    tail_mask_d = tail_mask_q;
    echo_num_d  = echo_num_q;
    timeout_d   = timeout_q;
    if (is_active(state_q)) begin
      if (abort) begin
        state_d = ST_ERR;
      end else if (!start) begin
        state_d = ST_IDLE;
      end else if (wdog_expired_s) begin
        state_d = ST_ERR;
      end else begin
        case (state_q)
          ST_WAIT_OPEN: begin
            if (win_open) state_d = ST_ACQ;
            else          state_d = ST_WAIT_OPEN;
          end
          ST_ACQ: begin
            if (win_close) begin
              idx_d = idx_inc_s;
              if (mode_q == MODE_SINGLE) begin
                state_d = ST_DONE;
              end else if (last_win_s) begin
                state_d = (mode_q == MODE_TRAIN_TAIL) ? ST_TAIL_WAIT : ST_DONE;
              end else begin
                state_d = ST_WAIT_OPEN;
              end
            end else begin
              state_d = ST_ACQ;
            end
          end
          ST_TAIL_WAIT: begin
            if (win_open) state_d = ST_TAIL_ACQ;
            else          state_d = ST_TAIL_WAIT;
          end
          ST_TAIL_ACQ: begin
            if (win_close) state_d = ST_DONE;
            else           state_d = ST_TAIL_ACQ;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          mode_d      = mode_in_s;
          ch_mask_d   = ch_mask;
          tail_mask_d = tail_mask;
          echo_num_d  = echo_num;
          timeout_d   = timeout;
          if (start) begin
            if ((mode_in_s != MODE_SINGLE) && (echo_num == {CNTW{1'b0}})) begin
              state_d = (mode_in_s == MODE_TRAIN_TAIL) ? ST_TAIL_WAIT : ST_DONE;
            end else begin
              state_d = ST_WAIT_OPEN;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE, ST_ERR: begin
          if (!start) state_d = ST_IDLE;
          else        state_d = state_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // The echo count reads zero whenever the sequencer sits in IDLE.
    if (state_d == ST_IDLE) begin
      idx_d = {CNTW{1'b0}};
    end else begin
      idx_d = idx_d;
    end
  end

  // Output decode from the next state so outputs react with no added cycle.
  always_comb begin
    en_d        = {NCH{1'b0}};
    busy_d      = is_active(state_d);
    stateover_d = 1'b1;
    err_d       = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      ST_ACQ:      en_d = ch_mask_q;
      ST_TAIL_ACQ: en_d = tail_mask_q;
      ST_DONE: begin
        stateover_d = 1'b0;
        done_d      = (state_q != ST_DONE);
      end
      ST_ERR: begin
        stateover_d = 1'b0;
        err_d       = 1'b1;
      end
      default: en_d = {NCH{1'b0}};
    endcase
  end

  // State, counter, config and registered outputs.
  always_ff @(posedge dds or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= {CNTW{1'b0}};
      mode_q      <= 2'd0;
      ch_mask_q   <= {NCH{1'b0}};
      tail_mask_q <= {NCH{1'b0}};
      echo_num_q  <= {CNTW{1'b0}};
      timeout_q   <= {TOW{1'b0}};
      en_q        <= {NCH{1'b0}};
      busy_q      <= 1'b0;
      stateover_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      ch_mask_q   <= ch_mask_d;
      tail_mask_q <= tail_mask_d;
      echo_num_q  <= echo_num_d;
      timeout_q   <= timeout_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      stateover_q <= stateover_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign en        = en_q;
  assign echo_idx  = idx_q;
  assign busy      = busy_q;
  assign stateover = stateover_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sd_acq_seq.sv
// Self-checking bench for sd_acq_seq: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_sd_acq_seq;

  localparam int NCH  = 2;
  localparam int CNTW = 16;
  localparam int TOW  = 20;
  localparam int IDX_MAX = (1 << CNTW) - 1;

  logic            dds = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [NCH-1:0]  ch_mask = '0;
  logic [NCH-1:0]  tail_mask = '0;
  logic [CNTW-1:0] echo_num = '0;
  logic [TOW-1:0]  timeout = '0;
  logic            win_open = 1'b0;
  logic            win_close = 1'b0;
  logic            abort = 1'b0;
  logic [NCH-1:0]  en;
  logic [CNTW-1:0] echo_idx;
  logic            busy, stateover, done, err;

  int errors = 0;
  int checks = 0;

  sd_acq_seq #(.NCH(NCH), .CNTW(CNTW), .TOW(TOW)) dut (
    .dds(dds), .rst(rst), .start(start), .mode(mode), .ch_mask(ch_mask),
    .tail_mask(tail_mask), .echo_num(echo_num), .timeout(timeout),
    .win_open(win_open), .win_close(win_close), .abort(abort),
    .en(en), .echo_idx(echo_idx), .busy(busy), .stateover(stateover),
    .done(done), .err(err)
  );

  always #5 dds = ~dds;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A sequence is described by: armed (m_run), window open, in tail part,
  // windows still to run, finished, failed, and cycles spent in the phase.
  bit m_run, m_open, m_tail, m_fin, m_fail, m_done;
  int m_left, m_age, m_idx;
  int c_mode, c_num, c_to;
  logic [NCH-1:0] c_ch, c_tail;

  task automatic model_reset();
    m_run = 0; m_open = 0; m_tail = 0; m_fin = 0; m_fail = 0; m_done = 0;
    m_left = 0; m_age = 0; m_idx = 0;
    c_mode = 0; c_num = 0; c_to = 0; c_ch = '0; c_tail = '0;
  endtask

  task automatic model_step();
    bit idle, was_run, was_open, was_tail, expired;
    idle = !m_run && !m_fin && !m_fail;
    was_run = m_run; was_open = m_open; was_tail = m_tail;
    m_done = 0;
    if (idle) begin
      c_mode = (mode == 2'd3) ? 0 : int'(mode);
      c_ch = ch_mask; c_tail = tail_mask;
      c_num = int'(echo_num); c_to = int'(timeout);
      if (start) begin
        if (c_mode != 0 && c_num == 0) begin
          if (c_mode == 2) begin m_run = 1; m_tail = 1; m_open = 0; m_left = 0; end
          else begin m_fin = 1; m_done = 1; end
        end else begin
          m_run = 1; m_open = 0; m_tail = 0;
          m_left = (c_mode == 0) ? 1 : c_num;
        end
      end
    end else if (m_run) begin
      expired = (c_to != 0) && (m_age + 1 == c_to);
      if (abort) begin m_run = 0; m_fail = 1; end
      else if (!start) m_run = 0;
      else if (expired) begin m_run = 0; m_fail = 1; end
      else if (!m_open) begin
        if (win_open) m_open = 1;
      end else if (win_close) begin
        m_open = 0;
        if (m_tail) begin m_run = 0; m_fin = 1; m_done = 1; end
        else begin
          if (m_idx < IDX_MAX) m_idx++;
          m_left--;
          if (m_left == 0) begin
            if (c_mode == 2) m_tail = 1;
            else begin m_run = 0; m_fin = 1; m_done = 1; end
          end
        end
      end
    end else begin
      if (!start) begin m_fin = 0; m_fail = 0; end
    end
    if (!m_run) begin m_open = 0; m_tail = 0; end
    if (!m_run && !m_fin && !m_fail) m_idx = 0;
    if (!m_run || m_run != was_run || m_open != was_open || m_tail != was_tail) m_age = 0;
    else m_age++;
  endtask

  // Advance the model on each edge, then compare every output 1 time unit later.
  always @(posedge dds) begin
    logic [NCH-1:0] exp_en;
    if (rst) model_reset();
    else model_step();
    #1;
    exp_en = (m_run && m_open) ? (m_tail ? c_tail : c_ch) : '0;
    chk("en", 32'(en), 32'(exp_en));
    chk("echo_idx", 32'(echo_idx), 32'(m_idx));
    chk("busy", 32'(busy), 32'(m_run));
    chk("stateover", 32'(stateover), 32'(!(m_fin || m_fail)));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_fail));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge dds);
      #2;
    end
  endtask

  task automatic do_open();
    win_open = 1'b1; tick(); win_open = 1'b0;
  endtask

  task automatic do_close();
    win_close = 1'b1; tick(); win_close = 1'b0;
  endtask

  task automatic end_seq();
    start = 1'b0; tick();
    chk("lit_back_idle_stateover", 32'(stateover), 32'd1);
  endtask

  initial begin
    tick(2);
    chk("lit_reset_en", 32'(en), 32'd0);
    chk("lit_reset_stateover", 32'(stateover), 32'd1);
    chk("lit_reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Single window on channel 0.
    mode = 2'd0; ch_mask = 2'b01; tail_mask = 2'b10; timeout = '0; echo_num = 16'd5;
    start = 1'b1; tick();
    chk("lit_m0_busy", 32'(busy), 32'd1);
    chk("lit_m0_en_wait", 32'(en), 32'd0);
    tick(3);
    do_open();
    chk("lit_m0_en_open", 32'(en), 32'b01);
    tick(4);
    chk("lit_m0_en_hold", 32'(en), 32'b01);
    do_close();
    chk("lit_m0_en_closed", 32'(en), 32'd0);
    chk("lit_m0_done", 32'(done), 32'd1);
    chk("lit_m0_stateover", 32'(stateover), 32'd0);
    tick();
    chk("lit_m0_done_once", 32'(done), 32'd0);
    end_seq();

    // Three-echo train.
    mode = 2'd1; echo_num = 16'd3; start = 1'b1; tick();
    for (int i = 1; i <= 3; i++) begin
      do_open();
      chk("lit_m1_en", 32'(en), 32'b01);
      do_close();
      chk("lit_m1_idx", 32'(echo_idx), 32'(i));
      chk("lit_m1_en_gap", 32'(en), 32'd0);
      chk("lit_m1_done", 32'(done), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    end_seq();

    // Two-echo train plus tail, then tail only.
    mode = 2'd2; echo_num = 16'd2; start = 1'b1; tick();
    for (int i = 0; i < 2; i++) begin
      do_open();
      chk("lit_m2_en", 32'(en), 32'b01);
      do_close();
    end
    tick();
    do_open();
    chk("lit_m2_tail_en", 32'(en), 32'b10);
    do_close();
    chk("lit_m2_done", 32'(done), 32'd1);
    chk("lit_m2_idx", 32'(echo_idx), 32'd2);
    end_seq();
    echo_num = 16'd0; start = 1'b1; tick();
    do_open();
    chk("lit_m2z_tail_en", 32'(en), 32'b10);
    do_close();
    chk("lit_m2z_done", 32'(done), 32'd1);
    chk("lit_m2z_idx", 32'(echo_idx), 32'd0);
    end_seq();

    // Watchdog of 8 cycles with no window event.
    mode = 2'd1; echo_num = 16'd2; timeout = 20'd8; start = 1'b1; tick();
    tick(7);
    chk("lit_wd_not_yet", 32'(err), 32'd0);
    tick();
    chk("lit_wd_err", 32'(err), 32'd1);
    chk("lit_wd_stateover", 32'(stateover), 32'd0);
    end_seq();
    timeout = '0;

    // Abort during the second echo window.
    mode = 2'd1; echo_num = 16'd3; start = 1'b1; tick();
    do_open(); do_close(); do_open();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("lit_abort_en", 32'(en), 32'd0);
    chk("lit_abort_err", 32'(err), 32'd1);
    chk("lit_abort_idx", 32'(echo_idx), 32'd1);
    end_seq();

    // Open and close together while waiting: window opens and stays open.
    mode = 2'd1; echo_num = 16'd2; start = 1'b1; tick();
    win_open = 1'b1; win_close = 1'b1; tick(); win_open = 1'b0; win_close = 1'b0;
    chk("lit_both_en", 32'(en), 32'b01);
    tick();
    chk("lit_both_hold", 32'(en), 32'b01);
    do_close();
    end_seq();

    // Asynchronous reset in the middle of a window.
    mode = 2'd3; ch_mask = 2'b11; start = 1'b1; tick();
    do_open();
    chk("lit_rst_pre_en", 32'(en), 32'b11);
    #1 rst = 1'b1;
    #1;
    chk("lit_rst_async_en", 32'(en), 32'd0);
    chk("lit_rst_async_stateover", 32'(stateover), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("lit_rst_restart_busy", 32'(busy), 32'd1);
    end_seq();

    // Randomized traffic checked by the model.
    for (int i = 0; i < 4000; i++) begin
      if (start) start = ($urandom_range(0, 39) != 0);
      else       start = ($urandom_range(0, 1) == 1);
      mode      = 2'($urandom_range(0, 3));
      ch_mask   = NCH'($urandom);
      tail_mask = NCH'($urandom);
      echo_num  = CNTW'($urandom_range(0, 4));
      timeout   = ($urandom_range(0, 2) == 0) ? TOW'($urandom_range(1, 12)) : '0;
      win_open  = ($urandom_range(0, 3) == 0);
      win_close = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 199) == 0);
      tick();
    end

    start = 1'b0; win_open = 1'b0; win_close = 1'b0; abort = 1'b0;
    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_acq_seq.md
# sd_acq_seq

Parametrised acquisition-window sequencer for the spin-echo receive path, clocked by the DDS clock. It arms on `start`, then opens and closes receive-enable windows on up to `NCH` channels as timer events arrive. It supports three modes: single window, N-echo train, and N-echo train plus one tail window. It adds an echo counter, a watchdog timeout, abort, and re-arming without reset, and reports completion through `stateover`/`done` and failure through `err`.

## Interface
Parameters:
- `NCH`, 2 — number of enable channels (≥1)
- `CNTW`, 16 — echo counter width
- `TOW`, 20 — watchdog counter width

Ports:
- `dds`  in  1  — clock; all state on its rising edge
- `rst`  in  1  — reset, asynchronous, active-high
- `start`  in  1  — level; high arms and holds a sequence, low returns to IDLE
- `mode`  in  2  — 0 single, 1 echo train, 2 train+tail, 3 reserved (treated as 0); sampled in IDLE
- `ch_mask`  in  NCH  — channels driven in train/single windows; sampled in IDLE
- `tail_mask`  in  NCH  — channels driven in tail window; sampled in IDLE
- `echo_num`  in  CNTW  — echo windows in modes 1/2; sampled in IDLE
- `timeout`  in  TOW  — watchdog limit in cycles, 0 disables; sampled in IDLE
- `win_open`  in  1  — timer event: open window
- `win_close`  in  1  — timer event: close window
- `abort`  in  1  — force ERR
- `en`  out  NCH  — receive enables
- `echo_idx`  out  CNTW  — completed train windows
- `busy`  out  1  — high in any state other than IDLE/DONE/ERR
- `stateover`  out  1  — high until sequence ends, low in DONE/ERR
- `done`  out  1  — one-cycle pulse on entering DONE
- `err`  out  1  — high in ERR

## Operation
- Reset values: state IDLE, `en`=0, `echo_idx`=0, `busy`=0, `stateover`=1, `done`=0, `err`=0, config latches 0.
- States: IDLE, WAIT_OPEN, ACQ, TAIL_WAIT, TAIL_ACQ, DONE, ERR.
- IDLE:
  - Latches config and clears `echo_idx` every cycle.
  - On `start`=1: goes to WAIT_OPEN.
  - Exception: mode 1/2 with `echo_num`=0 goes to TAIL_WAIT (mode 2) or DONE (mode 1).
- WAIT_OPEN: `win_open` → ACQ.
- ACQ:
  - `en`=`ch_mask`.
  - On `win_close`: `echo_idx`+1.
  - Mode 0: → DONE.
  - Mode 1/2: if `echo_idx`+1 == `echo_num` → DONE (mode 1) or TAIL_WAIT (mode 2); else → WAIT_OPEN.
- TAIL_WAIT: `win_open` → TAIL_ACQ.
- TAIL_ACQ: `en`=`tail_mask`; `win_close` → DONE.
- DONE: `stateover`=0, `en`=0; `start`=0 → IDLE (`stateover` back to 1).
- ERR: `err`=1, `stateover`=0, `en`=0; `start`=0 → IDLE.
- Priority, highest first: `abort` (any active state → ERR), `start`=0 (active state → IDLE, no `done`/`err`), watchdog expiry (→ ERR), window events.
- Watchdog:
  - Counts cycles spent in the current active state; cleared on every state change.
  - Expires when count == `timeout`, with `timeout`≠0.
- Simultaneous events:
  - `win_open`&`win_close` in a WAIT state: open wins, close ignored.
  - In ACQ states, `win_open` is ignored.
- `echo_idx` saturates at all-ones and never wraps; it holds its value in DONE/ERR.

## Timing
- Outputs are registered and decoded from next state. An event sampled at edge k changes `en`/`stateover`/`err` right after edge k, i.e. zero added cycles.
- `done` is high exactly the cycle after the edge entering DONE.
- Minimum window length is 1 cycle: `win_open` at edge k and `win_close` at edge k+1 gives `en` high for 1 cycle.
- `rst` asserted mid-sequence drops `en` asynchronously and forces reset values immediately.

## Structure
- Package `sd_acq_pkg` holds:
  - the state enum;
  - mode constants `MODE_SINGLE`, `MODE_TRAIN`, `MODE_TRAIN_TAIL`.
- Sub-module `sd_acq_wdog`:
  - ports: `dds`, `rst`, `clr`, `limit`, `expired`;
  - TOW-bit counter plus compare.

## Test plan
- Mode 0, `ch_mask`=2'b01, open at cycle 10, close at cycle 15 → `en`=01 for cycles 11–15, `done` pulse at cycle 16, `stateover`=0.
- Mode 1, `echo_num`=3, three open/close pairs → `echo_idx` steps 1,2,3, `done` after the third close, no `en` between windows.
- Mode 2, `echo_num`=2, `tail_mask`=2'b10 → two windows on 01, tail window on 10, then DONE; with `echo_num`=0 only the tail window occurs.
- `timeout`=8, no `win_open` after start → ERR after 8 cycles, `err`=1, `stateover`=0; `start` low → IDLE, `stateover`=1.
- `abort` mid-ACQ of echo 2 → `en`=0 next cycle, ERR, `echo_idx`=1; separately, `win_open`&`win_close` together in WAIT_OPEN → ACQ entered, window stays open.
- Async `rst` pulse during ACQ → `en`=0 with no clock edge; sequence restarts from IDLE.
